// File: rtl/arith_pkg.sv
// Shared constants and configuration checks for the arithmetic library.
package arith_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_STAGE_BITS = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit stage_cfg_ok(input int width, input int stage_bits);
    return (stage_bits > 0) && (width >= 2) && ((width % stage_bits) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/sub unit.
interface pipelined_addsub_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_slice.sv
// Combinational BITS-wide ripple adder; also exposes the carry into its top bit.
module adder_slice #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            c_msb_in
);

  always_comb begin : p_ripple
    logic c;
    c        = cin;
    c_msb_in = cin;
    sum      = '0;
    for (int i = 0; i < BITS; i++) begin
      if (i == BITS - 1) c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one STAGE_BITS slice per stage,
// carry registered between stages, valid/ready with per-stage backpressure.
module pipelined_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STAGE_BITS = DEF_STAGE_BITS
) (
  input logic               clk,
  input logic               rst,
  pipelined_addsub_if.slave bus
);

  localparam int STAGES = WIDTH / STAGE_BITS;

  if (!stage_cfg_ok(WIDTH, STAGE_BITS)) begin : g_cfg_check
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGE_BITS");
  end

  // acc_in[k]: unconsumed A slices at the low end, finished sum slices shifted in
  // at the top; after the last stage it holds the complete result in order.
  logic [WIDTH-1:0]  acc_in [STAGES+1];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic              c_in   [STAGES+1];
  logic              c_msb  [STAGES];
  logic [STAGES-1:0] vq;
  logic [STAGES-1:0] rdy;
  logic              ovf_q;

  assign acc_in[0] = bus.a;
  assign b_in[0]   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
  assign c_in[0]   = (bus.sub == MODE_ADD) ? bus.cin : 1'b1;

  // Unrolled ready chain: a stage may load if it or any stage after it is empty,
  // or the consumer is taking the result.
  always_comb begin : p_ready
    logic r;
    r   = bus.out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = r | ~vq[k];
      rdy[k] = r;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  v_up;
    logic                  take;
    logic                  valid_q;
    logic                  c_out;
    logic [STAGE_BITS-1:0] s_slice;
    logic [WIDTH-1:0]      acc_nxt;

    if (k == 0) begin : g_src
      assign v_up = bus.in_valid;
    end else begin : g_src
      assign v_up = vq[k-1];
    end

    assign take = rdy[k] & v_up;

    adder_slice #(
      .BITS(STAGE_BITS)
    ) u_slice (
      .a        (acc_in[k][STAGE_BITS-1:0]),
      .b        (b_in[k][STAGE_BITS-1:0]),
      .cin      (c_in[k]),
      .sum      (s_slice),
      .cout     (c_out),
      .c_msb_in (c_msb[k])
    );

    if (STAGES == 1) begin : g_acc
      assign acc_nxt = s_slice;
    end else begin : g_acc
      assign acc_nxt = {s_slice, acc_in[k][WIDTH-1:STAGE_BITS]};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (rdy[k]) begin
        valid_q <= v_up;
      end
    end

    assign vq[k] = valid_q;

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH-1:0] b_q;
      logic             c_q;

      always_ff @(posedge clk) begin
        if (take) begin
          acc_q <= acc_nxt;
          b_q   <= {{STAGE_BITS{1'b0}}, b_in[k][WIDTH-1:STAGE_BITS]};
          c_q   <= c_out;
        end
      end

      assign acc_in[k+1] = acc_q;
      assign b_in[k+1]   = b_q;
      assign c_in[k+1]   = c_q;
    end else begin : g_last
      logic [WIDTH-1:0] acc_q;
      logic             c_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
          c_q   <= 1'b0;
          ovf_q <= 1'b0;
        end else if (take) begin
          acc_q <= acc_nxt;
          c_q   <= c_out;
          ovf_q <= c_msb[k] ^ c_out;
        end
      end

      assign acc_in[k+1] = acc_q;
      assign c_in[k+1]   = c_q;
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vq[STAGES-1];
  assign bus.sum       = acc_in[STAGES];
  assign bus.cout      = c_in[STAGES];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, STAGE_BITS=4).
module tb_pipelined_addsub;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) bus ();

  pipelined_addsub #(.WIDTH(W), .STAGE_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W+1:0] exp_q [$];
  logic [W+1:0] obs_q [$];
  int           obs_cyc [$];
  logic         n_valid, n_ready;
  logic [W+1:0] n_res;

  // Reference: {sum, cout, ovf} from integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    int sa, sb, r;
    logic [W:0] u;
    logic co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
      r  = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      co = u[W];
      r  = sa + sb + int'(cin);
    end
    ov = (r > 32767) || (r < -32768);
    return {u[W-1:0], co, ov};
  endfunction

  task automatic step();
    @(negedge clk);
    n_valid = bus.out_valid;
    n_ready = bus.out_ready;
    n_res   = {bus.sum, bus.cout, bus.ovf};
    if (!rst && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    if (!rst && bus.out_valid && bus.out_ready) begin
      obs_q.push_back(n_res);
      obs_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1;
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    set_op(16'h0101, 16'h0202, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", bus.sum); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.cout, bus.ovf}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_accept got %0d want 0", exp_q.size()); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_idle_out got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_add_latency();
    int lat;
    clear_q();
    bus.out_ready = 1'b1;
    set_op(16'h1234, 16'h0FFF, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (lat < 0 && obs_q.size() > 0) lat = i;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL add_count got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== {16'h2234, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_result got %h want %h", obs_q[0], {16'h2234, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [3] = '{16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] tb [3] = '{16'h0001, 16'h0001, 16'h0001};
    logic         ts [3] = '{1'b0, 1'b0, 1'b1};
    logic [W+1:0] te [3] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1}, {16'h7FFF, 1'b1, 1'b1}};
    clear_q();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(ta[i], tb[i], 1'b0, ts[i]);
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_q[i] !== te[i]) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, obs_q[i], te[i]); end
        checks++; if (obs_cyc[i] != obs_cyc[0] + i) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_sub_cin_ignored();
    logic [W+1:0] want;
    want = {16'hFFFE, 1'b0, 1'b0};
    clear_q();
    bus.out_ready = 1'b1;
    set_op(16'h0003, 16'h0005, 1'b1, 1'b1);
    step();
    set_op(16'h0003, 16'h0005, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL sub_count got %0d want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (obs_q[i] !== want) begin errors++; $display("FAIL sub_result[%0d] got %h want %h", i, obs_q[i], want); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] hold;
    clear_q();
    bus.out_ready = 1'b0;
    hold = '0;
    for (int i = 0; i < 8; i++) begin
      set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      step();
      if (i == 4) hold = n_res;
    end
    checks++; if (exp_q.size() != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", exp_q.size()); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    checks++; if (n_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", n_valid); end
    checks++; if (n_res !== hold) begin errors++; $display("FAIL bp_stable got %h want %h", n_res, hold); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL bp_drain_count got %0d want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_drain[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        checks++; if (obs_cyc[i] != obs_cyc[0] + i) begin errors++; $display("FAIL bp_drain_spacing[%0d] got %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    clear_q();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    rst = 1'b1;
    set_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    step();
    clear_q();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    for (int i = 0; i < 8; i++) step();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_flushed got %0d want 0", obs_q.size()); end
    set_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (lat < 0 && obs_q.size() > 0) lat = i;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL rstmid_latency got %0d want 4", lat); end
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== {16'h0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rstmid_result got %h want %h", obs_q[0], {16'h0000, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    logic         p_stall;
    logic [W+1:0] p_res;
    int           n;
    clear_q();
    p_stall = 1'b0;
    p_res   = '0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = 16'($urandom);
      bus.b         = 16'($urandom);
      bus.cin       = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (p_stall) begin
        checks++;
        if (!n_valid || n_res !== p_res) begin
          errors++; $display("FAIL rand_stable cyc %0d got %b/%h want 1/%h", cyc, n_valid, n_res, p_res);
        end
      end
      p_stall = n_valid && !n_ready;
      p_res   = n_res;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_sub_cin_ignored();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
